// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator scheduler.
package elevator_pkg;

    localparam int unsigned DEF_N_FLOORS      = 8;
    localparam int unsigned DEF_TRAVEL_CYCLES = 16;
    localparam int unsigned DEF_DOOR_CYCLES   = 32;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_req_flags.sv
// Here/above/below request flags for one floor index, via one-hot mask compare.
module elevator_req_flags #(
    parameter int unsigned N_FLOORS = 8,
    parameter int unsigned FLOOR_W  = 3
) (
    input  logic [N_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]  floor_i,
    output logic                here_o_c,
    output logic                above_o_c,
    output logic                below_o_c
);

    logic [N_FLOORS-1:0] onehot;
    logic [N_FLOORS-1:0] below_mask;
    logic [N_FLOORS-1:0] above_mask;

    // Bits strictly below the index are (onehot - 1); the rest above it are the complement.
    assign onehot     = N_FLOORS'(1) << floor_i;
    assign below_mask = onehot - N_FLOORS'(1);
    assign above_mask = ~(onehot | below_mask);

    assign here_o_c  = |(pending_i & onehot);
    assign above_o_c = |(pending_i & above_mask);
    assign below_o_c = |(pending_i & below_mask);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: request bitmap, floor register, travel and door timers.
// Build option ELEV_DOOR_HOLD_EN adds the door_hold input.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned N_FLOORS      = DEF_N_FLOORS,
    parameter int unsigned FLOOR_W       = $clog2(N_FLOORS),
    parameter int unsigned TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    output logic                req_err,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                up,
    output logic                down,
    output logic                open,
    output logic                arrive,
    output logic                request_i,
    output logic                request_j_gt_i,
    output logic                request_j_lt_i
`ifdef ELEV_DOOR_HOLD_EN
    ,
    input  logic                door_hold
`endif
);

    localparam int unsigned TMR_W = $clog2(max_u(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [TMR_W-1:0]    travel_q, travel_d;
    logic [TMR_W-1:0]    door_q, door_d;
    logic                req_err_q, req_err_d;
    logic                arrive_q, arrive_d;
    logic                up_q, down_q, open_q;

    logic [FLOOR_W-1:0]  next_floor;
    logic [N_FLOORS-1:0] cur_oh, next_oh, req_oh;
    logic [N_FLOORS-1:0] set_mask, clr_mask;
    logic                req_in_range, door_reload, hold_c;
    logic                nxt_here, nxt_above, nxt_below;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold_c = door_hold;
`else
    assign hold_c = 1'b0;
`endif

    // Floor the car reaches when the running travel timer expires.
    assign next_floor   = (state_q == S_MOVE_DOWN) ? cur_floor_q - FLOOR_W'(1)
                                                   : cur_floor_q + FLOOR_W'(1);
    assign cur_oh       = N_FLOORS'(1) << cur_floor_q;
    assign next_oh      = N_FLOORS'(1) << next_floor;
    assign req_oh       = N_FLOORS'(1) << req_floor;
    assign req_in_range = 32'(req_floor) < N_FLOORS;

    elevator_req_flags #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_flags_cur (
        .pending_i (pending_q),
        .floor_i   (cur_floor_q),
        .here_o_c  (request_i),
        .above_o_c (request_j_gt_i),
        .below_o_c (request_j_lt_i)
    );

    elevator_req_flags #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_flags_next (
        .pending_i (pending_q),
        .floor_i   (next_floor),
        .here_o_c  (nxt_here),
        .above_o_c (nxt_above),
        .below_o_c (nxt_below)
    );

    // Next-state, request capture and timers.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        cur_floor_d = cur_floor_q;
        travel_d    = travel_q;
        door_d      = door_q;
        req_err_d   = 1'b0;
        arrive_d    = 1'b0;
        set_mask    = '0;
        clr_mask    = '0;
        door_reload = 1'b0;

        if (req_valid) begin
            if (!req_in_range) begin
                req_err_d = 1'b1;
            end else if ((state_q == S_DOOR) && (req_floor == cur_floor_q)) begin
                door_reload = 1'b1;
            end else begin
                set_mask = req_oh;
            end
        end
        if ((state_q == S_DOOR) && hold_c) begin
            door_reload = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (request_i) begin
                    state_d  = S_DOOR;
                    door_d   = DOOR_LOAD;
                    clr_mask = cur_oh;
                end else if (request_j_gt_i && ((dir_q == DIR_UP) || !request_j_lt_i)) begin
                    state_d  = S_MOVE_UP;
                    dir_d    = DIR_UP;
                    travel_d = TRAVEL_LOAD;
                end else if (request_j_lt_i) begin
                    state_d  = S_MOVE_DOWN;
                    dir_d    = DIR_DOWN;
                    travel_d = TRAVEL_LOAD;
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (travel_q != '0) begin
                    travel_d = travel_q - TMR_W'(1);
                end else begin
                    cur_floor_d = next_floor;
                    arrive_d    = 1'b1;
                    // Stop decision uses the registered bitmap, so a same-cycle request is not honoured.
                    if (nxt_here) begin
                        state_d  = S_DOOR;
                        door_d   = DOOR_LOAD;
                        clr_mask = next_oh;
                    end else if (((state_q == S_MOVE_UP) && nxt_above) ||
                                 ((state_q == S_MOVE_DOWN) && nxt_below)) begin
                        travel_d = TRAVEL_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                if (door_reload) begin
                    door_d = DOOR_LOAD;
                end else if (door_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    door_d = door_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_UP;
            cur_floor_q <= '0;
            pending_q   <= '0;
            travel_q    <= '0;
            door_q      <= '0;
            req_err_q   <= 1'b0;
            arrive_q    <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            open_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
            travel_q    <= travel_d;
            door_q      <= door_d;
            req_err_q   <= req_err_d;
            arrive_q    <= arrive_d;
            up_q        <= (state_d == S_MOVE_UP);
            down_q      <= (state_d == S_MOVE_DOWN);
            open_q      <= (state_d == S_DOOR);
        end
    end

    assign req_err   = req_err_q;
    assign pending   = pending_q;
    assign cur_floor = cur_floor_q;
    assign up        = up_q;
    assign down      = down_q;
    assign open      = open_q;
    assign arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Testbench for elevator_scheduler (door_hold scenario only with ELEV_DOOR_HOLD_EN).
module tb_elevator_scheduler;

    localparam int unsigned NF = 8;
    localparam int unsigned FW = 4;

    typedef enum int {EV_ARRIVE = 0, EV_DOOR = 1, EV_ERR = 2} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       floor;
        int       len;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic [FW-1:0] req_floor = '0;
    logic          req_err;
    logic [NF-1:0] pending;
    logic [FW-1:0] cur_floor;
    logic          up, down, open, arrive;
    logic          request_i, request_j_gt_i, request_j_lt_i;
`ifdef ELEV_DOOR_HOLD_EN
    logic          door_hold = 1'b0;
`endif

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    elevator_scheduler #(
        .N_FLOORS      (NF),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (16),
        .DOOR_CYCLES   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_floor      (req_floor),
        .req_err        (req_err),
        .pending        (pending),
        .cur_floor      (cur_floor),
        .up             (up),
        .down           (down),
        .open           (open),
        .arrive         (arrive),
        .request_i      (request_i),
        .request_j_gt_i (request_j_gt_i),
        .request_j_lt_i (request_j_lt_i)
`ifdef ELEV_DOOR_HOLD_EN
        ,
        .door_hold      (door_hold)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input int f, input int l);
        ev_t e;
        e.kind  = k;
        e.floor = f;
        e.len   = l;
        exp_q.push_back(e);
    endtask

    task automatic take(input ev_kind_e k, input int f, input int l);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d floor %0d len %0d expected none", k, f, l);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k != EV_ERR && (e.floor != f || e.len != l))) begin
                n_err++;
                $display("FAIL event: got kind %0d floor %0d len %0d expected kind %0d floor %0d len %0d",
                         k, f, l, e.kind, e.floor, e.len);
            end
        end
    endtask

    // Monitor: turns DUT pulses and door windows into events checked against the queue.
    initial begin
        int  cyc = 0;
        int  ref_cyc = 0;
        int  open_start = 0;
        int  open_floor = 0;
        logic prev_move = 1'b0;
        logic prev_open = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                prev_move = 1'b0;
                prev_open = 1'b0;
            end else begin
                if ((up || down) && !prev_move) ref_cyc = cyc;
                if (arrive) begin
                    take(EV_ARRIVE, int'(cur_floor), cyc - ref_cyc);
                    ref_cyc = cyc;
                end
                if (open && !prev_open) begin
                    open_start = cyc;
                    open_floor = int'(cur_floor);
                end
                if (!open && prev_open) take(EV_DOOR, open_floor, cyc - open_start);
                if (req_err) take(EV_ERR, 0, 0);
                prev_move = up || down;
                prev_open = open;
            end
        end
    end

    task automatic send_req(input int f);
        req_valid = 1'b1;
        req_floor = FW'(f);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(pending == '0 && !up && !down && !open) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", int'(k < 3000), 1);
    endtask

    task automatic wait_open();
        int k = 0;
        while (!open && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("open_timeout", int'(k < 500), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_cur_floor", int'(cur_floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_outs", int'({up, down, open, arrive, req_err}), 0);
        check("rst_flags", int'({request_i, request_j_gt_i, request_j_lt_i}), 0);

        // Single request to floor 3 from reset.
        expect_ev(EV_ARRIVE, 1, 16);
        expect_ev(EV_ARRIVE, 2, 16);
        expect_ev(EV_ARRIVE, 3, 16);
        expect_ev(EV_DOOR, 3, 32);
        send_req(3);
        check("s1_pending", int'(pending), 8);
        check("s1_up_t1", int'(up), 0);
        check("s1_flags", int'({request_i, request_j_gt_i, request_j_lt_i}), 3'b010);
        @(negedge clk);
        check("s1_up_t2", int'(up), 1);
        wait_idle();
        check("s1_floor", int'(cur_floor), 3);

        // SCAN ordering: heading to 6, requests for 5 and 1 arrive en route.
        expect_ev(EV_ARRIVE, 4, 16);
        expect_ev(EV_ARRIVE, 5, 16);
        expect_ev(EV_DOOR, 5, 32);
        expect_ev(EV_ARRIVE, 6, 16);
        expect_ev(EV_DOOR, 6, 32);
        for (int f = 5; f >= 1; f--) expect_ev(EV_ARRIVE, f, 16);
        expect_ev(EV_DOOR, 1, 32);
        send_req(6);
        repeat (2) @(negedge clk);
        send_req(5);
        send_req(1);
        check("s2_pending", int'(pending), 8'h62);
        check("s2_flags", int'({request_i, request_j_gt_i, request_j_lt_i}), 3'b011);
        wait_idle();
        check("s2_floor", int'(cur_floor), 1);

        // Same-floor request while the door has 10 cycles left.
        expect_ev(EV_ARRIVE, 2, 16);
        expect_ev(EV_DOOR, 2, 55);
        send_req(2);
        wait_open();
        repeat (22) @(negedge clk);
        send_req(2);
        check("s4_pending", int'(pending), 0);
        check("s4_open", int'(open), 1);
        wait_idle();

        // Asynchronous reset mid-travel between floors 4 and 5.
        expect_ev(EV_ARRIVE, 3, 16);
        expect_ev(EV_ARRIVE, 4, 16);
        send_req(7);
        begin
            int k = 0;
            while (cur_floor != FW'(4) && k < 500) begin
                @(negedge clk);
                k++;
            end
            check("s5_reach4", int'(k < 500), 1);
        end
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("s5_cur_floor", int'(cur_floor), 0);
        check("s5_pending", int'(pending), 0);
        check("s5_outs", int'({up, down, open, arrive, req_err}), 0);
        check("s5_flags", int'({request_i, request_j_gt_i, request_j_lt_i}), 0);
        @(negedge clk);
        rst_n = 1'b0;
        check("s5_q_empty", exp_q.size(), 0);

        // Out-of-range floors 8 and 9 are dropped with an error pulse.
        expect_ev(EV_ERR, 0, 0);
        expect_ev(EV_ERR, 0, 0);
        send_req(8);
        send_req(9);
        @(negedge clk);
        check("s3_pending", int'(pending), 0);
        check("s3_state", int'({up, down, open}), 0);

        // Request for the floor the idle car is already at.
        expect_ev(EV_DOOR, 0, 32);
        send_req(0);
        wait_idle();

`ifdef ELEV_DOOR_HOLD_EN
        // door_hold held for 100 cycles extends the dwell.
        expect_ev(EV_ARRIVE, 1, 16);
        expect_ev(EV_DOOR, 1, 132);
        send_req(1);
        wait_open();
        door_hold = 1'b1;
        repeat (100) @(negedge clk);
        check("s6_open_held", int'(open), 1);
        door_hold = 1'b0;
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        check("final_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
